// File: rtl/pdm_pkg.sv
// pdm_pkg: constants and types shared by the loadPDM output path and the pair FIFO.
//   PDM_WIDTH  - decimated sample width produced by loadPDM
//   CH_R/CH_F  - channel tags on the interleaved output stream
//   pdm_pair_t - one atomically stored sample pair {R,F}
package pdm_pkg;

    localparam int PDM_WIDTH = 12;

    localparam logic CH_R = 1'b0;
    localparam logic CH_F = 1'b1;

    typedef struct packed {
        logic [PDM_WIDTH-1:0] r;
        logic [PDM_WIDTH-1:0] f;
    } pdm_pair_t;

endpackage

// File: rtl/pdm_pair_fifo_if.sv
// pdm_pair_fifo_if: bus between the PDM front end, the pair FIFO and the consumer.
//   i_valid/i_dataR/i_dataF - sample pair strobe from loadPDM
//   o_data/o_chan/o_valid   - interleaved R,F word stream, i_ready accepts a word
//   o_count/o_overflow      - FIFO occupancy in pairs and sticky drop flag, i_clearOvf clears it
//   slave modport is the FIFO side, master modport is the producer/consumer side.
interface pdm_pair_fifo_if
    import pdm_pkg::*;
#(
    parameter int WIDTH  = PDM_WIDTH,
    parameter int ADDR_W = 4
);

    logic             i_valid;
    logic [WIDTH-1:0] i_dataR;
    logic [WIDTH-1:0] i_dataF;
    logic [WIDTH-1:0] o_data;
    logic             o_chan;
    logic             o_valid;
    logic             i_ready;
    logic [ADDR_W:0]  o_count;
    logic             o_overflow;
    logic             i_clearOvf;

    modport slave (
        input  i_valid, i_dataR, i_dataF, i_ready, i_clearOvf,
        output o_data, o_chan, o_valid, o_count, o_overflow
    );

    modport master (
        output i_valid, i_dataR, i_dataF, i_ready, i_clearOvf,
        input  o_data, o_chan, o_valid, o_count, o_overflow
    );

endinterface

// File: rtl/pdm_fifo_core.sv
// pdm_fifo_core: dual-pointer synchronous FIFO with registered-write memory.
//   i_clk/i_reset - clock, asynchronous active-high reset (pointers and count only)
//   i_push/i_wdata - write a word; caller guarantees not full unless popping
//   i_pop/o_rdata  - o_rdata shows the head word, i_pop advances past it
//   o_count/o_full/o_empty - occupancy 0..DEPTH
module pdm_fifo_core #(
    parameter int WIDTH  = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_rdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ADDR_W:0]   count_q, count_d;

    // Pointers are exactly ADDR_W bits so they wrap modulo DEPTH for free.
    always_comb begin
        wr_d    = wr_q + ADDR_W'(i_push);
        rd_d    = rd_q + ADDR_W'(i_pop);
        count_d = count_q + (ADDR_W+1)'(i_push) - (ADDR_W+1)'(i_pop);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rd_q];
    assign o_count = count_q;
    assign o_full  = count_q == (ADDR_W+1)'(DEPTH);
    assign o_empty = count_q == '0;

endmodule

// File: rtl/pdm_pair_fifo.sv
// pdm_pair_fifo: buffers loadPDM sample pairs and emits them as an R-then-F word stream.
//   i_clk/i_reset - clock, asynchronous active-high reset
//   bus (slave)   - pair input strobe, valid/ready word output, occupancy and overflow
// A pair is stored whole in the FIFO; the output register holds the pair being
// emitted plus which half (R or F) is currently presented.
module pdm_pair_fifo
    import pdm_pkg::*;
#(
    parameter int WIDTH  = PDM_WIDTH,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    pdm_pair_fifo_if.slave bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_R     = 2'd1;
    localparam logic [1:0] ST_F     = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] pair_q, pair_d, head;
    logic               ovf_q, ovf_d;
    logic               push, pop, drop, full, empty;
    logic [ADDR_W:0]    count;

    pdm_fifo_core #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_core (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_push (push),
        .i_wdata({bus.i_dataR, bus.i_dataF}),
        .i_pop  (pop),
        .o_rdata(head),
        .o_count(count),
        .o_full (full),
        .o_empty(empty)
    );

    // A pop frees a slot in the same cycle, so a full FIFO still takes a pair
    // whenever the F word leaves and the head moves into the output register.
    always_comb begin
        pop     = !empty && (state_q == ST_EMPTY || (state_q == ST_F && bus.i_ready));
        push    = bus.i_valid && (!full || pop);
        drop    = bus.i_valid && !push;
        ovf_d   = drop || (ovf_q && !bus.i_clearOvf);
        pair_d  = pop ? head : pair_q;
        state_d = pop                               ? ST_R     :
                  (state_q == ST_R && bus.i_ready)  ? ST_F     :
                  (state_q == ST_F && bus.i_ready)  ? ST_EMPTY : state_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_EMPTY;
            pair_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_valid    = state_q != ST_EMPTY;
    assign bus.o_chan     = (state_q == ST_F) ? CH_F : CH_R;
    assign bus.o_data     = (state_q == ST_F) ? pair_q[WIDTH-1:0] : pair_q[2*WIDTH-1:WIDTH];
    assign bus.o_count    = count;
    assign bus.o_overflow = ovf_q;

endmodule
